// File: rtl/rc5_key_schedule.sv
// ----------------------------------------------------------------------------
// rc5_key_schedule
//   RC5 key-expansion mixing engine. It walks the S table (T words) and the
//   L table (C key words) that live in external synchronous-read RAMs, and
//   performs N = 3*max(T,C) iterations of
//       A = S[i] = rotl(S[i] + A + B, 3)
//       B = L[j] = rotl(L[j] + A + B, A + B)
//   Each iteration takes four cycles: RD (present addresses), MIX_S, MIX_L
//   and WR (write both tables back).
//
//   Optional feature, macro KEYMIX_INIT_EN:
//     defined   - an INIT phase of T cycles first fills S[t] = P_W + t*Q_W.
//     undefined - no INIT state; the S RAM must be preloaded externally.
//
// Parameters
//   W  word width (16, 32 or 64)
//   T  S-table depth, 2*(rounds+1), 2..255
//   C  L-table depth (key words), 1..255
//
// Ports
//   clk         clock, all state on the rising edge
//   rst_n       asynchronous active-low reset
//   iStart      start request, only looked at while idle
//   oBusy       high whenever the engine is not idle
//   oDone       one-cycle completion pulse
//   oS_address  S-RAM address (read data valid one edge after the address)
//   iS_data     S-RAM read data
//   oS_data     S-RAM write data
//   oS_we       S-RAM write enable
//   oL_address  L-RAM address (same timing as S)
//   iL_data     L-RAM read data
//   oL_data     L-RAM write data
//   oL_we       L-RAM write enable
// ----------------------------------------------------------------------------
module rc5_key_schedule #(
  parameter int W = 32,
  parameter int T = 26,
  parameter int C = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 iStart,
  output logic                                 oBusy,
  output logic                                 oDone,
  output logic [$clog2(T)-1:0]                 oS_address,
  input  logic [W-1:0]                         iS_data,
  output logic [W-1:0]                         oS_data,
  output logic                                 oS_we,
  output logic [((C > 1) ? $clog2(C) : 1)-1:0] oL_address,
  input  logic [W-1:0]                         iL_data,
  output logic [W-1:0]                         oL_data,
  output logic                                 oL_we
);

  localparam int SAW = $clog2(T);
  localparam int LAW = (C > 1) ? $clog2(C) : 1;
  localparam int N   = 3 * ((T > C) ? T : C);
  localparam int KW  = $clog2(N);
  localparam int RW  = $clog2(W);

  localparam logic [2:0] ST_IDLE  = 3'd0;
`ifdef KEYMIX_INIT_EN
  localparam logic [2:0] ST_INIT  = 3'd1;
`endif
  localparam logic [2:0] ST_RD    = 3'd2;
  localparam logic [2:0] ST_MIX_S = 3'd3;
  localparam logic [2:0] ST_MIX_L = 3'd4;
  localparam logic [2:0] ST_WR    = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

`ifdef KEYMIX_INIT_EN
  // Magic constants; the 16-bit pair is not a truncation of the wider ones.
  localparam logic [W-1:0] P_W = (W == 16) ? W'(16'hB7E1) :
                                 (W == 32) ? W'(32'hB7E15163) :
                                             W'(64'hB7E151628AED2A6B);
  localparam logic [W-1:0] Q_W = (W == 16) ? W'(16'h9E37) :
                                 (W == 32) ? W'(32'h9E3779B9) :
                                             W'(64'h9E3779B97F4A7C15);
`endif

  logic [2:0]     state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [SAW-1:0] i_q, i_d;
  logic [LAW-1:0] j_q, j_d;
  logic [KW-1:0]  k_q, k_d;
  logic [W-1:0]   ab_sum;

  // Rotate left by 0..W-1: the upper half of {x,x} shifted left is exactly
  // the rotated word, and a shift of 0 returns x unchanged.
  function automatic logic [W-1:0] rotl(input logic [W-1:0] x,
                                        input logic [RW-1:0] s);
    logic [2*W-1:0] dbl;
    dbl = {x, x} << s;
    return dbl[2*W-1:W];
  endfunction

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    // In MIX_L this already holds the freshly mixed A.
    ab_sum  = a_q + b_q;
    case (state_q)
      ST_IDLE: begin
        if (iStart) begin
          a_d = '0;
          b_d = '0;
          i_d = '0;
          j_d = '0;
          k_d = '0;
`ifdef KEYMIX_INIT_EN
          state_d = ST_INIT;
`else
          state_d = ST_RD;
`endif
        end
      end
`ifdef KEYMIX_INIT_EN
      // A doubles as the t*Q accumulator here; it is cleared before mixing.
      ST_INIT: begin
        if (i_q == SAW'(T - 1)) begin
          i_d     = '0;
          a_d     = '0;
          state_d = ST_RD;
        end else begin
          i_d = i_q + 1'b1;
          a_d = a_q + Q_W;
        end
      end
`endif
      ST_RD:    state_d = ST_MIX_S;
      ST_MIX_S: begin
        a_d     = rotl(iS_data + ab_sum, RW'(3));
        state_d = ST_MIX_L;
      end
      ST_MIX_L: begin
        b_d     = rotl(iL_data + ab_sum, ab_sum[RW-1:0]);
        state_d = ST_WR;
      end
      ST_WR: begin
        i_d     = (i_q == SAW'(T - 1)) ? '0 : i_q + 1'b1;
        j_d     = (j_q == LAW'(C - 1)) ? '0 : j_q + 1'b1;
        k_d     = k_q + 1'b1;
        state_d = (k_q == KW'(N - 1)) ? ST_DONE : ST_RD;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
    end
  end

  // Outputs decode directly from registered state so reset clears them at once.
  assign oBusy      = (state_q != ST_IDLE);
  assign oDone      = (state_q == ST_DONE);
  assign oS_address = i_q;
  assign oL_address = j_q;
  assign oL_data    = b_q;
  assign oL_we      = (state_q == ST_WR);
`ifdef KEYMIX_INIT_EN
  assign oS_data    = (state_q == ST_INIT) ? (a_q + P_W) : a_q;
  assign oS_we      = (state_q == ST_WR) || (state_q == ST_INIT);
`else
  assign oS_data    = a_q;
  assign oS_we      = (state_q == ST_WR);
`endif

endmodule
